// File: rtl/cla_accum.sv
// Frame accumulator built around a 4-bit-group carry-lookahead adder.
// Sums a valid/ready stream of words per frame and holds the
// {carry-count, low-word} sum and the word count until downstream takes it.
//
// CLA_Adder ports:
//   i_data_one, i_data_two : addends (DATA_WIDTH)
//   o_data                 : low DATA_WIDTH bits of the sum
//   o_carry                : carry out of the top bit
//
// cla_accum ports:
//   i_clk, i_rst_n         : clock (rising edge), async active-low reset
//   i_valid, o_ready       : input word handshake
//   i_data, i_last         : operand word, final-word-of-frame marker
//   o_valid, i_ready       : result handshake
//   o_sum, o_sum_hi        : low word of frame sum, count of carries out
//   o_count                : words accepted in the frame (saturating)

module CLA_Adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data_one,
    input  logic [DATA_WIDTH-1:0] i_data_two,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_carry
);

    // Operands are zero-padded up to a whole number of 4-bit groups.
    localparam int NG = (DATA_WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] w_a;
    logic [PW-1:0] w_b;
    logic [PW-1:0] w_p;
    logic [PW-1:0] w_g;
    logic [PW:0]   w_c;
    logic [NG-1:0] w_gp;
    logic [NG-1:0] w_gg;
    logic [NG:0]   w_gc;
    logic          w_tg;
    logic          w_tp;

    // Kept in one process so the carry chain is evaluated in order.
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_a[DATA_WIDTH-1:0] = i_data_one;
        w_b[DATA_WIDTH-1:0] = i_data_two;
        w_p = w_a ^ w_b;
        w_g = w_a & w_b;

        // Group generate / propagate.
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < NG; k++) begin
            w_tg = 1'b0;
            w_tp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                w_tg = w_g[4*k+j] | (w_p[4*k+j] & w_tg);
                w_tp = w_tp & w_p[4*k+j];
            end
            w_gg[k] = w_tg;
            w_gp[k] = w_tp;
        end

        // Carry between groups, no carry-in.
        w_gc = '0;
        for (int k = 0; k < NG; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end

        // Carries inside each group, seeded by the group carry.
        w_c = '0;
        for (int k = 0; k < NG; k++) begin
            w_c[4*k] = w_gc[k];
            for (int j = 1; j < 4; j++) begin
                w_c[4*k+j] = w_g[4*k+j-1]
                           | (w_p[4*k+j-1] & w_c[4*k+j-1]);
            end
        end
        w_c[PW] = w_gc[NG];

        o_data  = w_p[DATA_WIDTH-1:0] ^ w_c[DATA_WIDTH-1:0];
        o_carry = w_c[DATA_WIDTH];
    end

endmodule

module cla_accum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic [DATA_WIDTH-1:0] o_sum_hi,
    output logic [15:0]           o_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_sum_hi;
    logic [15:0]           r_count;
    logic [DATA_WIDTH-1:0] w_add;
    logic                  w_carry;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    CLA_Adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .i_data_one (r_sum),
        .i_data_two (i_data),
        .o_data     (w_add),
        .o_carry    (w_carry)
    );

    // Handshakes use the registered outputs only.
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = o_valid && i_ready;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_in_xfer) begin
                    w_next = i_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (w_out_xfer) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state alone.
    always_comb begin
        o_ready = 1'b1;
        o_valid = 1'b0;
        unique case (r_state)
            S_IDLE, S_ACCUM: begin
                o_ready = 1'b1;
                o_valid = 1'b0;
            end
            S_HOLD: begin
                o_ready = 1'b0;
                o_valid = 1'b1;
            end
            default: begin
                o_ready = 1'b1;
                o_valid = 1'b0;
            end
        endcase
    end

    // Frame datapath. The first word of a frame loads rather than adds,
    // so a finished result stays visible in IDLE until the next frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum    <= '0;
            r_sum_hi <= '0;
            r_count  <= '0;
        end else if (w_in_xfer) begin
            if (r_state == S_IDLE) begin
                r_sum    <= i_data;
                r_sum_hi <= '0;
                r_count  <= 16'd1;
            end else begin
                r_sum    <= w_add;
                r_sum_hi <= r_sum_hi
                          + {{(DATA_WIDTH-1){1'b0}}, w_carry};
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
            end
        end
    end

    assign o_sum    = r_sum;
    assign o_sum_hi = r_sum_hi;
    assign o_count  = r_count;

endmodule

// File: tb/tb_cla_accum.sv
// Bench for cla_accum: directed frames checked against a wide-integer
// frame-sum model every cycle, plus hand-computed literal results.

module tb_cla_accum;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          i_last;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_sum;
    logic [DW-1:0] o_sum_hi;
    logic [15:0]   o_count;

    int n_chk  = 0;
    int n_fail = 0;

    cla_accum #(
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_sum_hi (o_sum_hi),
        .o_count  (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: the frame sum is one 2*DW-bit integer; the high half is
    // the carry count, the low half the low word.
    logic          m_hold;
    logic          m_inframe;
    logic [2*DW-1:0] m_sum;
    int            m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold    = 1'b0;
            m_inframe = 1'b0;
            m_sum     = '0;
            m_cnt     = 0;
        end else if (m_hold) begin
            if (i_ready) begin
                m_hold    = 1'b0;
                m_inframe = 1'b0;
            end
        end else if (i_valid) begin
            if (!m_inframe) begin
                m_sum     = {{DW{1'b0}}, i_data};
                m_cnt     = 1;
                m_inframe = 1'b1;
            end else begin
                m_sum = m_sum + {{DW{1'b0}}, i_data};
                m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            end
            if (i_last) m_hold = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("valid", {63'd0, o_valid}, {63'd0, m_hold});
        chk("ready", {63'd0, o_ready}, {63'd0, !m_hold});
        chk("sum", {32'd0, o_sum}, {32'd0, m_sum[DW-1:0]});
        chk("sum_hi", {32'd0, o_sum_hi}, {32'd0, m_sum[2*DW-1:DW]});
        chk("count", {48'd0, o_count}, 64'(m_cnt[15:0]));
    end

    task automatic send(input logic [DW-1:0] d, input logic l);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
    endtask

    task automatic expect_result(input string nm, input logic [DW-1:0] s,
                                 input logic [DW-1:0] hi,
                                 input logic [15:0] c);
        int k;
        k = 0;
        while (!o_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'd0);
        chk({nm, "_sum"}, {32'd0, o_sum}, {32'd0, s});
        chk({nm, "_hi"}, {32'd0, o_sum_hi}, {32'd0, hi});
        chk({nm, "_cnt"}, {48'd0, o_count}, {48'd0, c});
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk({nm, "_idle"}, {63'd0, o_valid}, 64'd0);
    endtask

    logic [DW-1:0] tbl [0:11];

    initial begin
        tbl = '{32'h80000000, 32'h80000000, 32'h7fffffff, 32'h00000001,
                32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                32'hdeadbeef, 32'hcafef00d, 32'h0badf00d, 32'hfeedface};
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_cnt", {48'd0, o_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h1023ac52, 1'b1);
        expect_result("single", 32'h1023ac52, 32'd0, 16'd1);

        send(32'hd7c812ea, 1'b0);
        send(32'hf2000105, 1'b1);
        expect_result("carry", 32'hc9c813ef, 32'd1, 16'd2);

        send(32'hffffffff, 1'b0);
        send(32'hffffffff, 1'b0);
        send(32'h00000002, 1'b1);
        expect_result("multi", 32'h00000000, 32'd2, 16'd3);

        send(32'h0000000f, 1'b0);
        repeat (3) @(negedge clk);
        send(32'hfffffff1, 1'b1);
        expect_result("bubble", 32'h00000000, 32'd1, 16'd2);

        // Backpressure: held result ignores incoming words.
        send(32'h12345678, 1'b1);
        i_valid = 1'b1;
        i_data  = 32'h00000005;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, o_valid}, 64'd1);
            chk("bp_ready", {63'd0, o_ready}, 64'd0);
            chk("bp_sum", {32'd0, o_sum}, 64'h12345678);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        i_valid = 1'b0;
        chk("bp_idle_valid", {63'd0, o_valid}, 64'd0);
        chk("bp_idle_ready", {63'd0, o_ready}, 64'd1);
        chk("bp_keep_sum", {32'd0, o_sum}, 64'h12345678);
        chk("bp_keep_cnt", {48'd0, o_count}, 64'd1);

        // Reset mid-frame, checked before the next clock edge.
        send(32'h000ff000, 1'b0);
        send(32'h00011000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_sum", {32'd0, o_sum}, 64'd0);
        chk("mrst_cnt", {48'd0, o_count}, 64'd0);
        chk("mrst_ready", {63'd0, o_ready}, 64'd1);
        chk("mrst_valid", {63'd0, o_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h00000005, 1'b1);
        expect_result("post_rst", 32'h00000005, 32'd0, 16'd1);

        // Further frames checked by the model alone.
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 4; w++) begin
                send(tbl[f*4+w], (w == 3));
                if (w == 1) @(negedge clk);
            end
            repeat (2) @(negedge clk);
            i_ready = 1'b1;
            @(negedge clk);
            i_ready = 1'b0;
        end
        send(32'h80000000, 1'b0);
        send(32'h80000000, 1'b1);
        expect_result("wrap", 32'h00000000, 32'd1, 16'd2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cla_accum.md
CLA_ACCUM -- requirements
Module: cla_accum

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the data words, sum words and adder.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_valid, input, 1 bit: upstream word valid.
REQ-005 SHALL have port o_ready, output, 1 bit: block can accept a word.
REQ-006 SHALL have port i_data, input, DATA_WIDTH bits: operand word.
REQ-007 SHALL have port i_last, input, 1 bit: marks the final word of a frame; qualified by i_valid.
REQ-008 SHALL have port o_valid, output, 1 bit: frame result valid.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port o_sum, output, DATA_WIDTH bits: low word of the frame sum.
REQ-011 SHALL have port o_sum_hi, output, DATA_WIDTH bits: count of carries out of the low word (high word of the sum).
REQ-012 SHALL have port o_count, output, 16 bits: number of words accepted in the frame.

Function
REQ-013 SHALL perform every low-word addition with one instance of CLA_Adder.
- Ports: i_data_one = accumulator, i_data_two = i_data, o_data, o_carry.
- No carry-in.
REQ-014 SHALL define an input transfer as i_valid && o_ready at a rising edge of i_clk.
REQ-015 SHALL define an output transfer as o_valid && i_ready at a rising edge of i_clk.
REQ-016 SHALL implement exactly three states:
- IDLE: o_ready=1, o_valid=0.
- ACCUM: o_ready=1, o_valid=0.
- HOLD: o_ready=0, o_valid=1.
REQ-017 In IDLE, an input transfer SHALL load the frame:
- o_sum <= i_data, o_sum_hi <= 0, o_count <= 1.
- Next state is HOLD if i_last, else ACCUM.
REQ-018 In ACCUM, an input transfer SHALL update the frame:
- o_sum <= adder o_data.
- o_sum_hi <= o_sum_hi + adder o_carry, wrapping modulo 2^DATA_WIDTH.
- o_count <= o_count + 1, saturating at 16'hFFFF.
- Next state is HOLD if i_last, else stay in ACCUM.
REQ-019 A cycle with i_valid=0 in IDLE or ACCUM SHALL leave state and all outputs unchanged (bubbles are allowed mid-frame).
REQ-020 Latency: o_valid SHALL assert in the cycle immediately after the transfer carrying i_last.
REQ-021 In HOLD, o_sum, o_sum_hi and o_count SHALL remain stable until the output transfer; i_valid, i_data and i_last SHALL be ignored.
REQ-022 An output transfer SHALL return the block to IDLE with o_valid=0 in the next cycle.
- Results stay visible until the next frame loads.
- No word is accepted in the same cycle as the output transfer.
REQ-023 A new frame's first word SHALL be accepted no earlier than the cycle after the output transfer.
REQ-024 o_ready and o_valid SHALL be driven only from the state register, with no combinational path from i_valid or i_ready.

Reset
REQ-025 While i_rst_n=0, asynchronously and regardless of i_clk, the block SHALL:
- enter IDLE;
- clear o_sum, o_sum_hi and o_count to 0;
- drive o_valid=0 and o_ready=1.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or held result.
- The first transfer after reset release is treated as the first word of a new frame.

Verification
REQ-027 Single word: one transfer 32'h1023ac52 with i_last=1 -> next cycle o_valid=1, o_sum=32'h1023ac52, o_sum_hi=0, o_count=1.
REQ-028 Carry: transfers 32'hd7c812ea, then 32'hf2000105 with i_last=1 -> o_sum=32'hc9c813ef, o_sum_hi=1, o_count=2.
REQ-029 Multiple carries: transfers 32'hffffffff, 32'hffffffff, then 32'h00000002 with i_last=1 -> o_sum=32'h00000000, o_sum_hi=2, o_count=3.
REQ-030 Bubbles: transfer 32'h0000000f, then i_valid=0 for 3 cycles, then 32'hfffffff1 with i_last=1 -> o_sum=0, o_sum_hi=1, o_count=2.
REQ-031 Backpressure: in HOLD, i_ready=0 for 5 cycles while i_valid=1 with 32'h00000005 -> o_valid stays 1, o_ready stays 0, outputs unchanged; i_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-frame: reset pulse after 32'h000ff000 and 32'h00011000 (no i_last) -> outputs 0 and state IDLE; then 32'h00000005 with i_last=1 -> o_sum=32'h00000005, o_count=1.
